// File: rtl/polyphase_phase_sched.sv
// Phase scheduler for the 2-stage polyphase decimator: /2 and /4 clock
// enables, phase index, and a fill-gated decimated valid strobe.
module polyphase_phase_sched #(
    parameter int unsigned SETTLE = 4,
    parameter int unsigned CW     = 8
) (
    input  logic       clk_i,
    input  logic       res_i,
    input  logic       en_i,
    input  logic       sync_i,
    input  logic [1:0] mode_i,
    output logic       ce_2_o,
    output logic       ce_4_o,
    output logic [1:0] phase_o,
    output logic       out_valid_o,
    output logic       busy_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam state_e START = (SETTLE == 0) ? RUN : FILL;
    localparam logic [CW-1:0] LAST = (SETTLE == 0) ? '0 : CW'(SETTLE - 1);

    state_e        state_q, state_d;
    logic [1:0]    ph_q, ph_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    mr_q, mr_d;

    logic busy;
    logic ce2;
    logic ce4;
    logic stb;

    assign busy = (state_q != IDLE);
    assign ce2  = busy & ph_q[0];
    assign ce4  = busy & (ph_q == 2'd3);

    always_comb begin
        stb = ce4;
        if (mr_q == 2'd0)
            stb = busy;
        else if (mr_q == 2'd1)
            stb = ce2;
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        mr_d    = mr_q;
        unique case (state_q)
            IDLE: begin
                ph_d  = 2'd0;
                cnt_d = '0;
                mr_d  = mode_i;
                if (en_i)
                    state_d = START;
            end
            FILL, RUN: begin
                if (!en_i) begin
                    state_d = IDLE;
                    ph_d    = 2'd0;
                    cnt_d   = '0;
                end else if (sync_i || (mode_i != mr_q)) begin
                    // realign and mode change share one restart path
                    state_d = START;
                    ph_d    = 2'd0;
                    cnt_d   = '0;
                    mr_d    = mode_i;
                end else begin
                    ph_d = ph_q + 2'd1;
                    if (state_q == FILL && stb) begin
                        if (cnt_q == LAST) begin
                            state_d = RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ph_d    = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!res_i) begin
            state_q <= IDLE;
            ph_q    <= 2'd0;
            cnt_q   <= '0;
            mr_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            mr_q    <= mr_d;
        end
    end

    assign ce_2_o      = ce2;
    assign ce_4_o      = ce4;
    assign phase_o     = ph_q;
    assign out_valid_o = (state_q == RUN) & stb;
    assign busy_o      = busy;
    assign state_o     = state_q;

endmodule

// File: doc/polyphase_phase_sched.md
# polyphase_phase_sched

Phase scheduler for the 2-stage polyphase decimation tree: from the single system clock it generates the per-stage clock-enable strobes (divide-by-2 and divide-by-4), the current polyphase phase index, and a decimated-output valid strobe. A fill state machine suppresses the valid strobe until the filter pipeline has settled. It sits beside the polyphase path tree and sequences it. It also handles start, stop, resynchronisation and mode changes.

## Interface

- SETTLE, 4, number of decimated-rate strobes discarded after start/resync before OUT_VALID is allowed (0..255)
- CW, 8, width of the settle counter (must hold SETTLE)

- CLK  input  1  system clock (full input sample rate)
- RES  input  1  reset; synchronous, active-low
- EN  input  1  run enable; level-sensitive
- SYNC  input  1  single-cycle phase realign request
- MODE  input  2  decimation: 0 = /1, 1 = /2, 2 = /4, 3 = treated as 2
- CE_2  output  1  enable for the /2 stage
- CE_4  output  1  enable for the /4 stage
- PHASE  output  2  current phase index 0..3
- OUT_VALID  output  1  decimated output sample valid
- BUSY  output  1  state != IDLE
- STATE  output  2  IDLE = 0, FILL = 1, RUN = 2

## Operation

- Registers: state, 2-bit phase counter PH, CW-bit settle counter CNT, registered mode copy MR.
- All outputs are decoded from registers only. There is no combinational path from an input to an output.
- PH is held at 0 in IDLE. In FILL and RUN it increments by 1 each CLK, mod 4. PHASE = PH.
- CE_2 = BUSY & PH[0] (high when PH is 1 or 3). CE_4 = BUSY & (PH == 3).
- Decimated strobe STB = BUSY for MR = 0, CE_2 for MR = 1, CE_4 for MR = 2 or 3.
- IDLE:
  - EN = 1 leads to FILL, or to RUN if SETTLE = 0.
  - PH = 0, CNT = 0, MR <= MODE.
- FILL:
  - CNT increments on each STB.
  - STB with CNT == SETTLE-1 leads to RUN next cycle.
  - OUT_VALID = 0.
- RUN: OUT_VALID = STB.
- EN = 0 in FILL or RUN leads to IDLE next cycle: PH = 0, CNT = 0. EN has priority over SYNC and mode change.
- SYNC = 1 in FILL or RUN:
  - Next cycle PH = 0, CNT = 0, state = FILL (RUN if SETTLE = 0).
  - Any STB in the SYNC cycle is not counted.
- MODE != MR while not IDLE: handled identically to SYNC, and MR <= MODE. SYNC together with a MODE change counts as one restart.
- SYNC in IDLE is ignored.

## Timing

- Reset (RES = 0 at an edge): next cycle state = IDLE, PH = 0, CNT = 0, MR = 0. All outputs are 0: CE_2, CE_4, PHASE, OUT_VALID, BUSY, STATE.
- RES = 0 overrides EN, SYNC and MODE. Reset mid-RUN drops all strobes in the following cycle.
- Cycle numbering: cycle 0 is the first cycle with state = FILL (EN sampled 1 at the preceding edge). PH = n mod 4 in cycle n.
- CE_2 is high in odd cycles. CE_4 is high in cycles 3, 7, 11, …
- Mode 2, SETTLE = 4:
  - STBs in cycles 3, 7, 11 and 15 are discarded.
  - RUN from cycle 16.
  - First OUT_VALID in cycle 19, then every 4 cycles.
- Mode 1, SETTLE = 4: STBs in cycles 1, 3, 5 and 7 are discarded. First OUT_VALID in cycle 9.
- Mode 0, SETTLE = 4: first OUT_VALID in cycle 4, then every cycle.
- Restart latency after SYNC or MODE change: identical to start from IDLE, with the cycle after the request as cycle 0.
- EN fall: BUSY, CE_2, CE_4 and OUT_VALID are 0 from the next cycle.

## Test plan

- Reset: hold RES = 0 for 3 cycles with EN = 1 and MODE = 2 → all outputs 0 and STATE = 0. Release → STATE = 1 at the next cycle, PH = 0.
- Mode 2, SETTLE = 4, EN held → CE_4 in cycles 3, 7, 11, …; STATE = 2 from cycle 16; OUT_VALID only in cycles 19, 23, 27; CE_2 in odd cycles.
- Mode 1 → first OUT_VALID in cycle 9, then every 2 cycles. Mode 0 → OUT_VALID continuous from cycle 4.
- SYNC pulse in RUN at PH = 2 → next cycle PH = 0 and STATE = 1; OUT_VALID resumes 19 cycles later (mode 2).
- MODE 2→1 change in RUN → treated as SYNC: first /2 OUT_VALID 9 cycles after the restart cycle 0. MODE = 3 behaves as mode 2.
- EN drop in FILL, EN drop in RUN, and RES = 0 mid-RUN → all strobes 0 in the next cycle. Re-enable → fill restarts from CNT = 0 (no early OUT_VALID).
